ifetch: RTL

- Instruction fetch stage directly downstream of the program counter.
- Reads the current pc and issues a word read to instruction memory over a req/ack handshake.
- Buffers returned instructions, tagged with their address, in a small FIFO for decode.
- Drives the PC's inc control so the PC advances once per accepted fetch.
- Supports flush: on a taken branch, all buffered and in-flight fetches are discarded.

---
 rtl/ifetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: reads the PC, fetches one word over a req/ack
// handshake and buffers {address, instruction} pairs in a small FIFO for decode.
// A flush discards everything buffered and any fetch still in flight.
module ifetch #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_pc,
    output logic          o_pc_inc,
    input  logic          i_flush,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_instr_valid,
    output logic [DW-1:0] o_instr,
    output logic [AW-1:0] o_instr_pc,
    input  logic          i_instr_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_instr    [DEPTH];
    logic [AW-1:0]   r_instr_pc [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_mem_req;
    logic            w_pc_inc;
    logic            w_latch_pc;
    logic            w_has_room;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    assign w_has_room = (r_count < CW'(DEPTH));
    assign w_valid    = (r_count != '0);
    // A fetch is accepted only when it is acked without a flush; this is the push.
    assign w_push     = w_pc_inc;
    assign w_pop      = w_valid & i_instr_ready;

    // Next-state and handshake outputs of the fetch FSM.
    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_pc_inc     = 1'b0;
        w_latch_pc   = 1'b0;
        case (r_state)
            StIdle: begin
                if (!i_flush && w_has_room) begin
                    w_latch_pc   = 1'b1;
                    w_state_next = StReq;
                end
            end
            StReq: begin
                w_mem_req = 1'b1;
                if (i_mem_ack) begin
                    // On flush the PC loads the branch target, so no increment.
                    w_pc_inc     = ~i_flush;
                    w_state_next = StIdle;
                end else if (i_flush) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                // Memory still owes us an ack for the abandoned request.
                w_mem_req = 1'b1;
                if (i_mem_ack) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // FSM state and request address registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch_pc) begin
                r_mem_addr <= i_pc;
            end
        end
    end

    // FIFO storage, pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_instr[i]    <= '0;
                r_instr_pc[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_instr[r_wr_ptr]    <= i_mem_rdata;
                r_instr_pc[r_wr_ptr] <= r_mem_addr;
                r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_mem_req     = w_mem_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_pc_inc      = w_pc_inc;
    assign o_instr_valid = w_valid;
    assign o_instr       = r_instr[r_rd_ptr];
    assign o_instr_pc    = r_instr_pc[r_rd_ptr];

endmodule
